pc_fetch: RTL and testbench

Instruction-fetch front end of the pipelined core. Holds the program counter, issues reads to a synchronous instruction memory, and registers the returned instruction into the IF/ID pipeline register. It sits directly downstream of the PC-select logic: the PC-select output (jump, or taken BRZ/BRN) arrives here as `in_redirect` together with the branch/jump target. A one-entry skid buffer keeps downstream stalls from losing any fetched instruction.

---
 rtl/pc_fetch.sv | 139 +++++++++++++
 tb/tb_pc_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: program counter, synchronous instruction-memory
// read issue, one-entry skid buffer and the IF/ID pipeline register.
module pc_fetch #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_stall,
  input  logic               in_redirect,
  input  logic [PC_W-1:0]    in_target,
  input  logic [INSTR_W-1:0] in_imem_data,
  output logic [PC_W-1:0]    out_imem_addr,
  output logic               out_imem_en,
  output logic               out_if_valid,
  output logic [PC_W-1:0]    out_if_pc,
  output logic [INSTR_W-1:0] out_if_instr
);

  typedef enum logic [1:0] {
    MODE_RESET,
    MODE_REDIRECT,
    MODE_STALL,
    MODE_RUN
  } mode_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  mode_t w_mode;

  logic [PC_W-1:0]    r_pc;
  logic               r_req_valid;
  logic [PC_W-1:0]    r_req_pc;
  logic               r_skid_valid;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic               r_if_valid;
  logic [PC_W-1:0]    r_if_pc;
  logic [INSTR_W-1:0] r_if_instr;

  // Cycle mode in priority order: reset, redirect, stall, run.
  always_comb begin
    w_mode = MODE_RUN;
    if (in_rst) begin
      w_mode = MODE_RESET;
    end else if (in_redirect) begin
      w_mode = MODE_REDIRECT;
    end else if (in_stall) begin
      w_mode = MODE_STALL;
    end
  end

  assign out_imem_en   = (w_mode == MODE_RUN);
  assign out_imem_addr = r_pc;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else begin
      unique case (w_mode)
        MODE_REDIRECT: begin
          r_pc        <= in_target;
          r_req_valid <= 1'b0;
        end
        MODE_RUN: begin
          r_pc        <= r_pc + PC_ONE;
          r_req_valid <= 1'b1;
          r_req_pc    <= r_pc;
        end
        default: begin
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // The skid entry only fills while stalled; no reads issue then, so it never overflows.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      unique case (w_mode)
        MODE_STALL: begin
          if (r_req_valid && !r_skid_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_pc    <= r_req_pc;
            r_skid_instr <= in_imem_data;
          end
        end
        MODE_RUN: begin
          r_skid_valid <= 1'b0;
        end
        default: begin
          r_skid_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else begin
      unique case (w_mode)
        MODE_REDIRECT: begin
          r_if_valid <= 1'b0;
        end
        MODE_RUN: begin
          if (r_skid_valid) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_skid_pc;
            r_if_instr <= r_skid_instr;
          end else if (r_req_valid) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_req_pc;
            r_if_instr <= in_imem_data;
          end else begin
            r_if_valid <= 1'b0;
          end
        end
        default: begin
          r_if_valid <= r_if_valid;
        end
      endcase
    end
  end

  assign out_if_valid = r_if_valid;
  assign out_if_pc    = r_if_pc;
  assign out_if_instr = r_if_instr;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed timing scenarios with literal
// expectations, then randomized traffic against a fetch-queue reference model.
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [7:0]  target;
  logic [31:0] imemData;
  logic [7:0]  imemAddr;
  logic        imemEn;
  logic        ifValid;
  logic [7:0]  ifPc;
  logic [31:0] ifInstr;

  logic [31:0] mem [256];

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0]  mPc;
  logic [7:0]  mQ [$];
  logic        mValid;
  logic [7:0]  mIfPc;
  logic [31:0] mIfInstr;
  bit          mReady = 1'b0;

  pc_fetch #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00)) dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .in_stall      (stall),
    .in_redirect   (redirect),
    .in_target     (target),
    .in_imem_data  (imemData),
    .out_imem_addr (imemAddr),
    .out_imem_en   (imemEn),
    .out_if_valid  (ifValid),
    .out_if_pc     (ifPc),
    .out_if_instr  (ifInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory; cycles without a read return junk so stale data is noticed.
  always @(posedge clk) begin
    if (imemEn) imemData <= mem[imemAddr];
    else        imemData <= $urandom;
  end

  // Reference: issued addresses queue up; a run cycle delivers the oldest one already returned.
  always @(posedge clk) begin
    if (rst) begin
      mPc      = 8'h00;
      mQ.delete();
      mValid   = 1'b0;
      mIfPc    = 8'h00;
      mIfInstr = 32'h0;
      mReady   = 1'b1;
    end else if (redirect) begin
      mPc    = target;
      mQ.delete();
      mValid = 1'b0;
    end else if (!stall) begin
      if (mQ.size() > 0) begin
        mIfPc    = mQ.pop_front();
        mIfInstr = mem[mIfPc];
        mValid   = 1'b1;
      end else begin
        mValid = 1'b0;
      end
      mQ.push_back(mPc);
      mPc = mPc + 8'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic d, input logic [7:0] t);
    @(posedge clk);
    #1;
    rst      = r;
    stall    = s;
    redirect = d;
    target   = t;
  endtask

  always @(negedge clk) begin
    if (mReady) begin
      checkOutput("model en", 32'(imemEn), 32'(!rst && !stall && !redirect));
      checkOutput("model addr", 32'(imemAddr), 32'(mPc));
      checkOutput("model valid", 32'(ifValid), 32'(mValid));
      if (mValid) begin
        checkOutput("model if_pc", 32'(ifPc), 32'(mIfPc));
        checkOutput("model if_instr", ifInstr, mIfInstr);
      end
    end
  end

  initial begin
    logic       r, s, d;
    logic [7:0] t;
    rst      = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    target   = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // Directed script; cycle 0 is the first cycle after reset release.
    for (int c = 0; c < 45; c++) begin
      r = (c == 32);
      s = (c == 16) || (c >= 20 && c <= 22) || (c == 26) || (c == 27) || (c == 31) || (c == 32);
      d = (c == 10) || (c == 27) || (c == 36);
      t = (c == 10) ? 8'h40 : (c == 27) ? 8'h80 : 8'hFD;
      applyStimulus(r, s, d, t);
      @(negedge clk);
      case (c)
        0:  begin checkOutput("rel c0 en", 32'(imemEn), 1); checkOutput("rel c0 addr", 32'(imemAddr), 0); end
        1:  checkOutput("rel c1 valid", 32'(ifValid), 0);
        2:  begin checkOutput("rel c2 valid", 32'(ifValid), 1); checkOutput("rel c2 pc", 32'(ifPc), 0);
                  checkOutput("rel c2 instr", ifInstr, 0); end
        9:  checkOutput("run c9 pc", 32'(ifPc), 7);
        10: checkOutput("redir c10 en", 32'(imemEn), 0);
        11: begin checkOutput("redir c11 addr", 32'(imemAddr), 32'h40); checkOutput("redir c11 valid", 32'(ifValid), 0); end
        12: checkOutput("redir c12 valid", 32'(ifValid), 0);
        13: begin checkOutput("redir c13 valid", 32'(ifValid), 1); checkOutput("redir c13 pc", 32'(ifPc), 32'h40); end
        14: checkOutput("redir c14 pc", 32'(ifPc), 32'h41);
        16: checkOutput("stall1 c16 pc", 32'(ifPc), 32'h43);
        17: checkOutput("stall1 c17 pc", 32'(ifPc), 32'h43);
        18: checkOutput("stall1 c18 pc", 32'(ifPc), 32'h44);
        19: checkOutput("stall1 c19 pc", 32'(ifPc), 32'h45);
        20: begin checkOutput("stall3 c20 en", 32'(imemEn), 0); checkOutput("stall3 c20 pc", 32'(ifPc), 32'h46); end
        22: begin checkOutput("stall3 c22 en", 32'(imemEn), 0); checkOutput("stall3 c22 pc", 32'(ifPc), 32'h46); end
        23: begin checkOutput("stall3 c23 pc", 32'(ifPc), 32'h46); checkOutput("stall3 c23 valid", 32'(ifValid), 1); end
        24: checkOutput("stall3 c24 pc", 32'(ifPc), 32'h47);
        25: checkOutput("stall3 c25 pc", 32'(ifPc), 32'h48);
        27: checkOutput("sr c27 pc", 32'(ifPc), 32'h49);
        28: begin checkOutput("sr c28 valid", 32'(ifValid), 0); checkOutput("sr c28 addr", 32'(imemAddr), 32'h80); end
        29: checkOutput("sr c29 valid", 32'(ifValid), 0);
        30: begin checkOutput("sr c30 pc", 32'(ifPc), 32'h80); checkOutput("sr c30 valid", 32'(ifValid), 1); end
        33: begin checkOutput("rstp c33 valid", 32'(ifValid), 0); checkOutput("rstp c33 pc", 32'(ifPc), 0);
                  checkOutput("rstp c33 addr", 32'(imemAddr), 0); checkOutput("rstp c33 instr", ifInstr, 0); end
        35: begin checkOutput("rstp c35 valid", 32'(ifValid), 1); checkOutput("rstp c35 pc", 32'(ifPc), 0); end
        37: checkOutput("wrap c37 addr", 32'(imemAddr), 32'hFD);
        39: checkOutput("wrap c39 pc", 32'(ifPc), 32'hFD);
        41: checkOutput("wrap c41 pc", 32'(ifPc), 32'hFF);
        42: checkOutput("wrap c42 pc", 32'(ifPc), 32'h00);
        43: checkOutput("wrap c43 pc", 32'(ifPc), 32'h01);
        default: ;
      endcase
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(99) == 0);
      d = ($urandom_range(14) == 0);
      s = ($urandom_range(3) == 0);
      t = ($urandom_range(3) == 0) ? 8'(8'hF8 + 8'($urandom_range(7))) : 8'($urandom);
      applyStimulus(r, s, d, t);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
